// File: rtl/eth_10g_mac_tx_st_frame_guard.sv
// Avalon-ST TX framing guard.
// Accepted beats pass through a framing FSM into a 2-entry FIFO skid buffer.
// The FSM closes malformed or overlong packets with EOP and error[0], and it
// discards stray beats. Abnormal events are tallied in saturating counters.
module eth_10g_mac_tx_st_frame_guard #(
    parameter int MAX_BEATS = 1520,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    output logic             in_ready,
    input  logic             in_valid,
    input  logic [63:0]      in_data,
    input  logic [2:0]       in_error,
    input  logic             in_startofpacket,
    input  logic             in_endofpacket,
    input  logic [2:0]       in_empty,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [63:0]      out_data,
    output logic [2:0]       out_error,
    output logic             out_startofpacket,
    output logic             out_endofpacket,
    output logic [2:0]       out_empty,
    output logic [CNT_W-1:0] stray_cnt,
    output logic [CNT_W-1:0] trunc_cnt,
    output logic [CNT_W-1:0] oversize_cnt
);

    localparam logic [1:0]  ST_IDLE   = 2'd0;
    localparam logic [1:0]  ST_IN_PKT = 2'd1;
    localparam logic [1:0]  ST_DROP   = 2'd2;
    localparam logic [16:0] MAX_BEATS_L = 17'(MAX_BEATS);

    // Stored beat layout: {data, error, sop, eop, empty}
    localparam int BEAT_W = 64 + 3 + 1 + 1 + 3;

    logic [1:0]        state_reg, state_next;
    logic [15:0]       beat_cnt_reg, beat_cnt_next;
    logic [BEAT_W-1:0] mem_reg [0:1];
    logic              wr_ptr_reg;
    logic              rd_ptr_reg;
    logic [1:0]        count_reg, count_next;
    logic              in_ready_reg;
    logic              out_valid_reg;

    logic              accept;
    logic              push;
    logic              pop;
    logic              forced;
    logic              f_sop;
    logic              f_eop;
    logic [2:0]        f_err;
    logic [2:0]        f_empty;
    logic [2:0]        cnt_inc;
    logic [CNT_W-1:0]  status_cnt_reg [0:2];

    assign accept = in_valid & in_ready_reg;
    assign pop    = out_valid_reg & out_ready;

    // Framing decision for the beat being accepted this cycle
    always_comb begin
        state_next    = state_reg;
        beat_cnt_next = beat_cnt_reg;
        push          = 1'b0;
        forced        = 1'b0;
        f_sop         = in_startofpacket;
        f_eop         = in_endofpacket;
        f_err         = in_error;
        cnt_inc       = 3'b000;
        if (accept) begin
            case (state_reg)
                ST_IDLE: begin
                    if (in_startofpacket) begin
                        push = 1'b1;
                        if (!in_endofpacket) begin
                            state_next    = ST_IN_PKT;
                            beat_cnt_next = 16'd1;
                        end
                    end else begin
                        cnt_inc[0] = 1'b1;
                    end
                end
                ST_IN_PKT: begin
                    push = 1'b1;
                    if (in_startofpacket) begin
                        // New packet started before the old one ended: close the old one
                        forced     = 1'b1;
                        f_sop      = 1'b0;
                        cnt_inc[1] = 1'b1;
                        state_next = ST_DROP;
                    end else if (in_endofpacket) begin
                        state_next = ST_IDLE;
                    end else if (({1'b0, beat_cnt_reg} + 17'd1) == MAX_BEATS_L) begin
                        forced     = 1'b1;
                        cnt_inc[2] = 1'b1;
                        state_next = ST_DROP;
                    end else begin
                        beat_cnt_next = beat_cnt_reg + 16'd1;
                    end
                end
                ST_DROP: begin
                    if (in_endofpacket) begin
                        state_next = ST_IDLE;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
        if (forced) begin
            f_eop    = 1'b1;
            f_err[0] = 1'b1;
        end
        f_empty = (f_eop && !forced) ? in_empty : 3'd0;
    end

    assign count_next = count_reg + {1'b0, push} - {1'b0, pop};

    // FSM, packet length and buffer bookkeeping
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= ST_IDLE;
            beat_cnt_reg  <= 16'd0;
            wr_ptr_reg    <= 1'b0;
            rd_ptr_reg    <= 1'b0;
            count_reg     <= 2'd0;
            in_ready_reg  <= 1'b0;
            out_valid_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            beat_cnt_reg  <= beat_cnt_next;
            count_reg     <= count_next;
            in_ready_reg  <= (count_next < 2'd2);
            out_valid_reg <= (count_next != 2'd0);
            if (push) wr_ptr_reg <= ~wr_ptr_reg;
            if (pop)  rd_ptr_reg <= ~rd_ptr_reg;
        end
    end

    // Buffer storage; cleared on reset so out_* payload reads zero
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_entry
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    mem_reg[gi] <= '0;
                end else if (push && (wr_ptr_reg == gi[0])) begin
                    mem_reg[gi] <= {in_data, f_err, f_sop, f_eop, f_empty};
                end
            end
        end
    endgenerate

    // Saturating status counters: 0 stray, 1 trunc, 2 oversize
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    status_cnt_reg[gi] <= '0;
                end else if (cnt_inc[gi] && (status_cnt_reg[gi] != {CNT_W{1'b1}})) begin
                    status_cnt_reg[gi] <= status_cnt_reg[gi] + 1'b1;
                end
            end
        end
    endgenerate

    assign in_ready     = in_ready_reg;
    assign out_valid    = out_valid_reg;
    assign {out_data, out_error, out_startofpacket, out_endofpacket, out_empty} = mem_reg[rd_ptr_reg];
    assign stray_cnt    = status_cnt_reg[0];
    assign trunc_cnt    = status_cnt_reg[1];
    assign oversize_cnt = status_cnt_reg[2];

endmodule

// File: tb/tb_eth_10g_mac_tx_st_frame_guard.sv
// Testbench for eth_10g_mac_tx_st_frame_guard: directed beats, scoreboard queue,
// and a monitor that compares each consumed output beat.
module tb_eth_10g_mac_tx_st_frame_guard;

    localparam int CNT_W = 2;

    typedef struct packed {
        logic [63:0] data;
        logic [2:0]  err;
        logic        sop;
        logic        eop;
        logic [2:0]  empty;
    } beat_t;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             in_ready;
    logic             in_valid = 1'b0;
    logic [63:0]      in_data = '0;
    logic [2:0]       in_error = '0;
    logic             in_startofpacket = 1'b0;
    logic             in_endofpacket = 1'b0;
    logic [2:0]       in_empty = '0;
    logic             out_ready = 1'b0;
    logic             out_valid;
    logic [63:0]      out_data;
    logic [2:0]       out_error;
    logic             out_startofpacket;
    logic             out_endofpacket;
    logic [2:0]       out_empty;
    logic [CNT_W-1:0] stray_cnt;
    logic [CNT_W-1:0] trunc_cnt;
    logic [CNT_W-1:0] oversize_cnt;

    int    n_vec = 0;
    int    n_err = 0;
    beat_t exp_q[$];

    eth_10g_mac_tx_st_frame_guard #(.MAX_BEATS(4), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_ready(in_ready), .in_valid(in_valid), .in_data(in_data),
        .in_error(in_error), .in_startofpacket(in_startofpacket),
        .in_endofpacket(in_endofpacket), .in_empty(in_empty),
        .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
        .out_error(out_error), .out_startofpacket(out_startofpacket),
        .out_endofpacket(out_endofpacket), .out_empty(out_empty),
        .stray_cnt(stray_cnt), .trunc_cnt(trunc_cnt), .oversize_cnt(oversize_cnt)
    );

    always #5 clk = ~clk;

    // Monitor: every consumed output beat must match the head of the scoreboard
    initial begin
        beat_t got;
        beat_t e;
        forever begin
            @(negedge clk);
            if (reset_n && out_valid && out_ready) begin
                got = {out_data, out_error, out_startofpacket, out_endofpacket, out_empty};
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL out_beat: unexpected beat got=%h required=none", got);
                end else begin
                    e = exp_q.pop_front();
                    if (got !== e) begin
                        n_err++;
                        $display("FAIL out_beat: got=%h required=%h", got, e);
                    end else begin
                        $display("out beat data=%h err=%b sop=%b eop=%b empty=%0d ok",
                                 got.data, got.err, got.sop, got.eop, got.empty);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got=%0h required=%0h", name, act, req);
        end else begin
            $display("check %s = %0h ok", name, act);
        end
    endtask

    // Present one beat, wait (bounded) for acceptance, queue the expected output.
    // Leaves in_valid high so consecutive calls stream back-to-back.
    task automatic send(input logic [63:0] d, input logic [2:0] e, input logic s,
                        input logic eo, input logic [2:0] em, input bit fwd,
                        input logic [2:0] xe, input logic xs, input logic xeo,
                        input logic [2:0] xem);
        bit acc;
        in_valid = 1'b1; in_data = d; in_error = e;
        in_startofpacket = s; in_endofpacket = eo; in_empty = em;
        acc = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (in_ready) begin
                acc = 1'b1;
                break;
            end
        end
        if (!acc) begin
            n_vec++;
            n_err++;
            $display("FAIL accept_timeout: got=in_ready_low required=accept data=%h", d);
        end else begin
            @(posedge clk);
            #1;
            if (fwd) exp_q.push_back('{data: d, err: xe, sop: xs, eop: xeo, empty: xem});
        end
    endtask

    task automatic drain();
        in_valid = 1'b0;
        for (int k = 0; k < 100 && exp_q.size() != 0; k++) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain: got=%0d pending required=0", exp_q.size());
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", out_data, 64'd0);
        chk("rst_counters", 64'({stray_cnt, trunc_cnt, oversize_cnt}), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("rel_in_ready_before_edge", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        chk("rel_in_ready_after_edge", 64'(in_ready), 64'd1);

        // 1: 3-beat packet, empty passed only on EOP
        out_ready = 1'b1;
        send(64'h1111_0000_0000_0001, 3'b000, 1, 0, 3'd3, 1, 3'b000, 1, 0, 3'd0);
        send(64'h1111_0000_0000_0002, 3'b010, 0, 0, 3'd2, 1, 3'b010, 0, 0, 3'd0);
        send(64'h1111_0000_0000_0003, 3'b000, 0, 1, 3'd5, 1, 3'b000, 0, 1, 3'd5);
        drain();
        chk("t1_counters", 64'({stray_cnt, trunc_cnt, oversize_cnt}), 64'd0);

        // 2: backpressure, buffer fills after 2 beats
        out_ready = 1'b0;
        send(64'h2222_0000_0000_0001, 3'b000, 1, 0, 3'd0, 1, 3'b000, 1, 0, 3'd0);
        send(64'h2222_0000_0000_0002, 3'b000, 0, 0, 3'd0, 1, 3'b000, 0, 0, 3'd0);
        @(negedge clk);
        chk("t2_full_in_ready", 64'(in_ready), 64'd0);
        chk("t2_full_out_valid", 64'(out_valid), 64'd1);
        repeat (3) @(negedge clk);
        chk("t2_still_full", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(64'h2222_0000_0000_0003, 3'b000, 0, 0, 3'd0, 1, 3'b000, 0, 0, 3'd0);
        send(64'h2222_0000_0000_0004, 3'b100, 0, 1, 3'd7, 1, 3'b100, 0, 1, 3'd7);
        drain();

        // 3: stray beat, then single-beat packet with 1-cycle latency
        send(64'h3333_0000_0000_0001, 3'b000, 0, 0, 3'd0, 0, 3'b000, 0, 0, 3'd0);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        send(64'h3333_0000_0000_0002, 3'b000, 1, 1, 3'd4, 1, 3'b000, 1, 1, 3'd4);
        in_valid = 1'b0;
        @(negedge clk);
        chk("t3_latency_out_valid", 64'(out_valid), 64'd1);
        drain();
        chk("t3_stray_cnt", 64'(stray_cnt), 64'd1);

        // 4: unexpected SOP truncates, rest of new packet dropped
        send(64'h4444_0000_0000_0001, 3'b000, 1, 0, 3'd0, 1, 3'b000, 1, 0, 3'd0);
        send(64'h4444_0000_0000_0002, 3'b000, 0, 0, 3'd0, 1, 3'b000, 0, 0, 3'd0);
        send(64'h4444_0000_0000_0003, 3'b000, 1, 0, 3'd6, 1, 3'b001, 0, 1, 3'd0);
        send(64'h4444_0000_0000_0004, 3'b000, 0, 0, 3'd0, 0, 3'b000, 0, 0, 3'd0);
        send(64'h4444_0000_0000_0005, 3'b000, 0, 1, 3'd1, 0, 3'b000, 0, 0, 3'd0);
        send(64'h4444_0000_0000_0006, 3'b000, 1, 0, 3'd0, 1, 3'b000, 1, 0, 3'd0);
        send(64'h4444_0000_0000_0007, 3'b000, 0, 1, 3'd2, 1, 3'b000, 0, 1, 3'd2);
        drain();
        chk("t4_trunc_cnt", 64'(trunc_cnt), 64'd1);
        chk("t4_stray_cnt", 64'(stray_cnt), 64'd1);

        // 5: exactly MAX_BEATS with EOP passes; 6-beat packet cut at beat 4
        send(64'h5555_0000_0000_0001, 3'b000, 1, 0, 3'd0, 1, 3'b000, 1, 0, 3'd0);
        send(64'h5555_0000_0000_0002, 3'b000, 0, 0, 3'd0, 1, 3'b000, 0, 0, 3'd0);
        send(64'h5555_0000_0000_0003, 3'b000, 0, 0, 3'd0, 1, 3'b000, 0, 0, 3'd0);
        send(64'h5555_0000_0000_0004, 3'b000, 0, 1, 3'd3, 1, 3'b000, 0, 1, 3'd3);
        drain();
        chk("t5_exact_max_oversize", 64'(oversize_cnt), 64'd0);
        send(64'h5555_0000_0001_0001, 3'b000, 1, 0, 3'd0, 1, 3'b000, 1, 0, 3'd0);
        send(64'h5555_0000_0001_0002, 3'b000, 0, 0, 3'd0, 1, 3'b000, 0, 0, 3'd0);
        send(64'h5555_0000_0001_0003, 3'b000, 0, 0, 3'd0, 1, 3'b000, 0, 0, 3'd0);
        send(64'h5555_0000_0001_0004, 3'b010, 0, 0, 3'd5, 1, 3'b011, 0, 1, 3'd0);
        send(64'h5555_0000_0001_0005, 3'b000, 0, 0, 3'd0, 0, 3'b000, 0, 0, 3'd0);
        send(64'h5555_0000_0001_0006, 3'b000, 0, 1, 3'd0, 0, 3'b000, 0, 0, 3'd0);
        send(64'h5555_0000_0001_0007, 3'b000, 1, 1, 3'd1, 1, 3'b000, 1, 1, 3'd1);
        drain();
        chk("t5_oversize_cnt", 64'(oversize_cnt), 64'd1);
        chk("t5_trunc_cnt", 64'(trunc_cnt), 64'd1);

        // Counter saturation at all-ones (CNT_W=2)
        send(64'h6666_0000_0000_0001, 3'b000, 0, 0, 3'd0, 0, 3'b000, 0, 0, 3'd0);
        send(64'h6666_0000_0000_0002, 3'b000, 0, 1, 3'd0, 0, 3'b000, 0, 0, 3'd0);
        drain();
        chk("sat_stray_reach", 64'(stray_cnt), 64'd3);
        send(64'h6666_0000_0000_0003, 3'b000, 0, 0, 3'd0, 0, 3'b000, 0, 0, 3'd0);
        drain();
        chk("sat_stray_hold", 64'(stray_cnt), 64'd3);

        // 6: reset mid-packet with 2 buffered beats
        out_ready = 1'b0;
        send(64'h7777_0000_0000_0001, 3'b000, 1, 0, 3'd0, 1, 3'b000, 1, 0, 3'd0);
        send(64'h7777_0000_0000_0002, 3'b000, 0, 0, 3'd0, 1, 3'b000, 0, 0, 3'd0);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        exp_q.delete();
        chk("t6_rst_out_valid", 64'(out_valid), 64'd0);
        chk("t6_rst_in_ready", 64'(in_ready), 64'd0);
        chk("t6_rst_counters", 64'({stray_cnt, trunc_cnt, oversize_cnt}), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("t6_in_ready_before_edge", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        chk("t6_in_ready_after_edge", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        send(64'h7777_0000_0000_0003, 3'b000, 0, 1, 3'd0, 0, 3'b000, 0, 0, 3'd0);
        drain();
        chk("t6_stray_after_reset", 64'(stray_cnt), 64'd1);
        chk("t6_no_leftover_valid", 64'(out_valid), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
